spi_burst_reg_master: RTL

//   Parametrised SPI register-access master for ADXL362-class sensors.

---
 rtl/spi_burst_reg_master_if.sv | 36 +++
 rtl/spi_burst_reg_master.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_reg_master_if.sv
// Request, write, read and SPI pin bundle for spi_burst_reg_master.
// The master modport is the block's own view; slave is the client/board side.
interface spi_burst_reg_master_if #(
  parameter int NUM_CS    = 2,
  parameter int MAX_BYTES = 8
);
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int LW  = $clog2(MAX_BYTES + 1);

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_read_i;
  logic [CSW-1:0]    req_cs_i;
  logic [7:0]        req_addr_i;
  logic [LW-1:0]     req_len_i;
  logic [7:0]        wr_data_i;
  logic              wr_ready_o;
  logic [7:0]        rd_data_o;
  logic              rd_valid_o;
  logic              done_o;
  logic              err_o;
  logic              sclk_o;
  logic              mosi_o;
  logic              miso_i;
  logic [NUM_CS-1:0] cs_n_o;

  modport master (
    input  req_valid_i, req_read_i, req_cs_i, req_addr_i, req_len_i, wr_data_i, miso_i,
    output req_ready_o, wr_ready_o, rd_data_o, rd_valid_o, done_o, err_o, sclk_o, mosi_o, cs_n_o
  );

  modport slave (
    output req_valid_i, req_read_i, req_cs_i, req_addr_i, req_len_i, wr_data_i, miso_i,
    input  req_ready_o, wr_ready_o, rd_data_o, rd_valid_o, done_o, err_o, sclk_o, mosi_o, cs_n_o
  );
endinterface

// File: rtl/spi_burst_reg_master.sv
// SPI mode-0 burst register master (command, address, 1..MAX_BYTES data bytes).
// Optional macro SPI_CS_GAP_EN adds a GAP state holding cs_n high for CS_GAP cycles.
module spi_burst_reg_master #(
  parameter int CLK_DIV   = 4,
  parameter int NUM_CS    = 2,
  parameter int MAX_BYTES = 8,
  parameter int CS_GAP    = 8
) (
  input logic clk,
  input logic rst,
  spi_burst_reg_master_if.master bus
);
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int LW  = $clog2(MAX_BYTES + 1);
  localparam int DW  = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, FINISH
`ifdef SPI_CS_GAP_EN
    , GAP
`endif
  } state_t;

  state_t         state_q, state_d;
  logic           setup_q, setup_d;
  logic [DW-1:0]  div_q, div_d;
  logic [2:0]     bit_q, bit_d;
  logic [LW-1:0]  byte_q, byte_d;
  logic [7:0]     sh_q, sh_d;
  logic [7:0]     rx_q, rx_d;
  logic [7:0]     addr_q, addr_d;
  logic           read_q, read_d;
  logic [CSW-1:0] cs_q, cs_d;
  logic [7:0]     rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           err_q, err_d;
`ifdef SPI_CS_GAP_EN
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP + 1) : 1;
  logic [GW-1:0]  gap_q, gap_d;
`endif

  logic wr_ready;
  logic bad_req;
  logic shifting;
  logic mosi;

  assign bad_req  = (bus.req_len_i == '0) || (bus.req_len_i > LW'(MAX_BYTES)) ||
                    (int'(bus.req_cs_i) >= NUM_CS);
  // setup_q marks the single cs-to-first-bit setup cycle after accept
  assign shifting = (state_q inside {CMD, ADDR, DATA}) && !setup_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      setup_q    <= 1'b0;
      div_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      addr_q     <= '0;
      read_q     <= 1'b0;
      cs_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef SPI_CS_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      setup_q    <= setup_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      cs_q       <= cs_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
`ifdef SPI_CS_GAP_EN
      gap_q      <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    setup_d    = 1'b0;
    div_d      = div_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    addr_d     = addr_q;
    read_d     = read_q;
    cs_d       = cs_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    wr_ready   = 1'b0;
`ifdef SPI_CS_GAP_EN
    gap_d      = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            state_d = CMD;
            setup_d = 1'b1;
            div_d   = '0;
            bit_d   = '0;
            read_d  = bus.req_read_i;
            cs_d    = bus.req_cs_i;
            addr_d  = bus.req_addr_i;
            byte_d  = bus.req_len_i;
            sh_d    = bus.req_read_i ? 8'h0B : 8'h0A;
          end
        end
      end
      CMD, ADDR, DATA: begin
        if (!setup_q) begin
          if (state_q == DATA && !read_q && bit_q == 3'd0 && div_q == '0) begin
            wr_ready = 1'b1;
            sh_d     = bus.wr_data_i;
          end
          if (div_q == DIV_RISE) begin
            rx_d = {rx_q[6:0], bus.miso_i};
            if (state_q == DATA && read_q && bit_q == 3'd7) begin
              rd_data_d  = {rx_q[6:0], bus.miso_i};
              rd_valid_d = 1'b1;
            end
          end
          if (div_q == DIV_LAST) begin
            div_d = '0;
            bit_d = bit_q + 3'd1;
            sh_d  = {sh_q[6:0], 1'b0};
            if (bit_q == 3'd7) begin
              if (state_q == CMD) begin
                state_d = ADDR;
                sh_d    = addr_q;
              end else if (state_q == ADDR) begin
                state_d = DATA;
              end else if (byte_q == LW'(1)) begin
                state_d = FINISH;
              end else begin
                byte_d = byte_q - LW'(1);
              end
            end
          end else begin
            div_d = div_q + DW'(1);
          end
        end
      end
      FINISH: begin
`ifdef SPI_CS_GAP_EN
        state_d = GAP;
        gap_d   = GW'(CS_GAP - 1);
`else
        state_d = IDLE;
`endif
      end
`ifdef SPI_CS_GAP_EN
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // During the load cycle of a write byte the shifter is not yet loaded, so drive its MSB directly.
  always_comb begin
    mosi = 1'b0;
    if (shifting) begin
      if (state_q == DATA) mosi = read_q ? 1'b0 : (wr_ready ? bus.wr_data_i[7] : sh_q[7]);
      else                 mosi = sh_q[7];
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.done_o      = (state_q == FINISH);
  assign bus.err_o       = err_q;
  assign bus.rd_data_o   = rd_data_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.wr_ready_o  = wr_ready;
  assign bus.sclk_o      = shifting && (div_q >= DIV_RISE);
  assign bus.mosi_o      = mosi;
  assign bus.cs_n_o      = (state_q inside {CMD, ADDR, DATA}) ? ~(NUM_CS'(1) << cs_q) : '1;
endmodule
